// File: rtl/sequenciador_exibe_joga_if.sv
// Controller <-> datapath/status bundle for the show-then-repeat game controller.
// The master side is the controller; the slave side is the datapath and game front-end.
interface sequenciador_exibe_joga_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       enderecoIgualSequencia;
  logic       fimL;
  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       registraR;
  logic       leds_en;
  logic       pronto;
  logic       ganhou;
  logic       perdeu;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, jogada, igual, enderecoIgualSequencia, fimL,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR, leds_en,
    output pronto, ganhou, perdeu, timeout, db_estado
  );

  modport slave (
    output iniciar, jogada, igual, enderecoIgualSequencia, fimL,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR, leds_en,
    input  pronto, ganhou, perdeu, timeout, db_estado
  );
endinterface

// File: rtl/sequenciador_exibe_joga.sv
// Moore controller for the show-then-repeat game: replays the stored sequence, then checks moves.
// Optional macro TIMEOUT_EN builds the per-move timeout timer and the FIM_TIMEOUT exit.
module sequenciador_exibe_joga #(
  parameter int SHOW_CYCLES    = 1000,
  parameter int GAP_CYCLES     = 250,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                       clock,
  input  logic                       reset,
  sequenciador_exibe_joga_if.master  bus
);

  localparam logic [3:0] INICIAL      = 4'h0;
  localparam logic [3:0] PREPARA      = 4'h1;
  localparam logic [3:0] INI_MOSTRA   = 4'h2;
  localparam logic [3:0] MOSTRA       = 4'h3;
  localparam logic [3:0] APAGA        = 4'h4;
  localparam logic [3:0] PROX_MOSTRA  = 4'h5;
  localparam logic [3:0] INI_JOGADA   = 4'h6;
  localparam logic [3:0] ESPERA       = 4'h7;
  localparam logic [3:0] REGISTRA     = 4'h8;
  localparam logic [3:0] COMPARA      = 4'h9;
  localparam logic [3:0] PROX_JOGADA  = 4'hA;
  localparam logic [3:0] PROX_NIVEL   = 4'hB;
  localparam logic [3:0] FIM_ACERTOU  = 4'hC;
  localparam logic [3:0] FIM_ERROU    = 4'hD;
  localparam logic [3:0] FIM_TIMEOUT  = 4'hE;

  // One pacing timer serves both the show and the gap phases.
  localparam int PACE_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int PACE_W   = (PACE_MAX > 1) ? $clog2(PACE_MAX) : 1;
  localparam logic [PACE_W-1:0] SHOW_LAST = PACE_W'(SHOW_CYCLES - 1);
  localparam logic [PACE_W-1:0] GAP_LAST  = PACE_W'(GAP_CYCLES - 1);
  localparam logic [PACE_W-1:0] PACE_ONE  = PACE_W'(1);
  localparam logic [PACE_W-1:0] PACE_ZERO = PACE_W'(0);

  // Output vector order: zeraE contaE zeraL contaL zeraR registraR leds_en pronto ganhou perdeu timeout
  function automatic logic [10:0] decode_outputs(input logic [3:0] st);
    logic [10:0] o;
    case (st)
      PREPARA:     o = 11'b101_010_0_0000;
      INI_MOSTRA:  o = 11'b100_000_0_0000;
      MOSTRA:      o = 11'b000_000_1_0000;
      PROX_MOSTRA: o = 11'b010_000_0_0000;
      INI_JOGADA:  o = 11'b100_000_0_0000;
      REGISTRA:    o = 11'b000_001_0_0000;
      PROX_JOGADA: o = 11'b010_000_0_0000;
      PROX_NIVEL:  o = 11'b000_100_0_0000;
      FIM_ACERTOU: o = 11'b000_000_0_1100;
      FIM_ERROU:   o = 11'b000_000_0_1010;
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: o = 11'b000_000_0_1011;
`endif
      default:     o = 11'b000_000_0_0000;
    endcase
    return o;
  endfunction

  logic [3:0]        state_r;
  logic [3:0]        next_state_s;
  logic [PACE_W-1:0] pace_r;
  logic [PACE_W-1:0] pace_next_s;
  logic [10:0]       outs_r;

`ifdef TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);
  logic [TMO_W-1:0] tmo_r;
  logic [TMO_W-1:0] tmo_next_s;
`endif

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      INICIAL:     if (bus.iniciar) next_state_s = PREPARA; else next_state_s = INICIAL;
      PREPARA:     next_state_s = INI_MOSTRA;
      INI_MOSTRA:  next_state_s = MOSTRA;
      MOSTRA:      if (pace_r == SHOW_LAST) next_state_s = APAGA; else next_state_s = MOSTRA;
      APAGA: begin
        if (pace_r == GAP_LAST) begin
          if (bus.enderecoIgualSequencia) next_state_s = INI_JOGADA;
          else                            next_state_s = PROX_MOSTRA;
        end else begin
          next_state_s = APAGA;
        end
      end
      PROX_MOSTRA: next_state_s = MOSTRA;
      INI_JOGADA:  next_state_s = ESPERA;
      ESPERA: begin
        if (bus.jogada)              next_state_s = REGISTRA;
`ifdef TIMEOUT_EN
        else if (tmo_r == TMO_LAST)  next_state_s = FIM_TIMEOUT;
`endif
        else                         next_state_s = ESPERA;
      end
      REGISTRA:    next_state_s = COMPARA;
      COMPARA: begin
        if (!bus.igual)                       next_state_s = FIM_ERROU;
        else if (!bus.enderecoIgualSequencia) next_state_s = PROX_JOGADA;
        else if (bus.fimL)                    next_state_s = FIM_ACERTOU;
        else                                  next_state_s = PROX_NIVEL;
      end
      PROX_JOGADA: next_state_s = ESPERA;
      PROX_NIVEL:  next_state_s = INI_MOSTRA;
      FIM_ACERTOU: if (bus.iniciar) next_state_s = PREPARA; else next_state_s = FIM_ACERTOU;
      FIM_ERROU:   if (bus.iniciar) next_state_s = PREPARA; else next_state_s = FIM_ERROU;
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: if (bus.iniciar) next_state_s = PREPARA; else next_state_s = FIM_TIMEOUT;
`endif
      default:     next_state_s = INICIAL;
    endcase
  end

  // Pacing timer: restarts for each shown value and again for the dark gap after it.
  always_comb begin
    pace_next_s = pace_r;
    case (state_r)
      INI_MOSTRA, PROX_MOSTRA: pace_next_s = PACE_ZERO;
      MOSTRA: begin
        if (pace_r == SHOW_LAST) pace_next_s = PACE_ZERO;
        else                     pace_next_s = pace_r + PACE_ONE;
      end
      APAGA: begin
        if (pace_r == GAP_LAST) pace_next_s = pace_r;
        else                    pace_next_s = pace_r + PACE_ONE;
      end
      default: pace_next_s = pace_r;
    endcase
  end

`ifdef TIMEOUT_EN
  // Move timeout timer: restarts before each move, saturates at its terminal count.
  always_comb begin
    tmo_next_s = tmo_r;
    case (state_r)
      INI_JOGADA, PROX_JOGADA: tmo_next_s = TMO_ZERO;
      ESPERA: begin
        if (tmo_r == TMO_LAST) tmo_next_s = tmo_r;
        else                   tmo_next_s = tmo_r + TMO_ONE;
      end
      default: tmo_next_s = tmo_r;
    endcase
  end

  // Move timeout timer register.
  always_ff @(posedge clock) begin
    if (reset) tmo_r <= TMO_ZERO;
    else       tmo_r <= tmo_next_s;
  end
`endif

  // State, pacing timer and outputs; outputs are decoded from the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= INICIAL;
      pace_r  <= PACE_ZERO;
      outs_r  <= 11'b0;
    end else begin
      state_r <= next_state_s;
      pace_r  <= pace_next_s;
      outs_r  <= decode_outputs(next_state_s);
    end
  end

  assign bus.zeraE     = outs_r[10];
  assign bus.contaE    = outs_r[9];
  assign bus.zeraL     = outs_r[8];
  assign bus.contaL    = outs_r[7];
  assign bus.zeraR     = outs_r[6];
  assign bus.registraR = outs_r[5];
  assign bus.leds_en   = outs_r[4];
  assign bus.pronto    = outs_r[3];
  assign bus.ganhou    = outs_r[2];
  assign bus.perdeu    = outs_r[1];
  assign bus.timeout   = outs_r[0];
  assign bus.db_estado = state_r;

endmodule

// File: tb/tb_sequenciador_exibe_joga.sv
// Directed bench for sequenciador_exibe_joga with SHOW=4, GAP=2, TIMEOUT=10.
// Works with and without TIMEOUT_EN defined.
module tb_sequenciador_exibe_joga;
  logic clock;
  logic reset;
  int   checks;
  int   failures;

  sequenciador_exibe_joga_if bus ();

  sequenciador_exibe_joga #(
    .SHOW_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected outputs per state, order: zeraE contaE zeraL contaL zeraR registraR leds_en pronto ganhou perdeu timeout
  localparam logic [10:0] O_NONE = 11'b000_000_0_0000;
  localparam logic [10:0] O_PREP = 11'b101_010_0_0000;
  localparam logic [10:0] O_ZE   = 11'b100_000_0_0000;
  localparam logic [10:0] O_LED  = 11'b000_000_1_0000;
  localparam logic [10:0] O_CE   = 11'b010_000_0_0000;
  localparam logic [10:0] O_REG  = 11'b000_001_0_0000;
  localparam logic [10:0] O_CL   = 11'b000_100_0_0000;
  localparam logic [10:0] O_WIN  = 11'b000_000_0_1100;
  localparam logic [10:0] O_LOSE = 11'b000_000_0_1010;
  localparam logic [10:0] O_TMO  = 11'b000_000_0_1011;

  function automatic logic [10:0] observed_outputs();
    return {bus.zeraE, bus.contaE, bus.zeraL, bus.contaL, bus.zeraR, bus.registraR,
            bus.leds_en, bus.pronto, bus.ganhou, bus.perdeu, bus.timeout};
  endfunction

  // Advance one clock, then compare state code and output vector away from the edge.
  task automatic step(input string tag, input logic [3:0] exp_state, input logic [10:0] exp_out);
    logic [10:0] obs;
    @(posedge clock);
    #1;
    obs = observed_outputs();
    checks = checks + 1;
    assert (bus.db_estado === exp_state)
    else begin
      failures = failures + 1;
      $error("FAIL %s state observed=%h expected=%h", tag, bus.db_estado, exp_state);
    end
    checks = checks + 1;
    assert (obs === exp_out)
    else begin
      failures = failures + 1;
      $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp_out);
    end
  endtask

  // Playback of one value: 4 lit cycles then 2 dark cycles.
  task automatic show_one(input string tag);
    for (int i = 0; i < 4; i++) step(tag, 4'h3, O_LED);
    step(tag, 4'h4, O_NONE);
    step(tag, 4'h4, O_NONE);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    bus.igual   = 1'b0;
    bus.enderecoIgualSequencia = 1'b1;
    bus.fimL    = 1'b0;

    step("reset_a", 4'h0, O_NONE);
    step("reset_b", 4'h0, O_NONE);
    reset = 1'b0;
    step("idle", 4'h0, O_NONE);

    // Round 1 (L=0): one shown value, jogada outside ESPERA ignored.
    bus.iniciar = 1'b1;
    step("prepara", 4'h1, O_PREP);
    bus.iniciar = 1'b0;
    step("ini_mostra", 4'h2, O_ZE);
    bus.jogada = 1'b1;
    step("r1_led0", 4'h3, O_LED);
    bus.jogada = 1'b0;
    step("r1_led1", 4'h3, O_LED);
    step("r1_led2", 4'h3, O_LED);
    step("r1_led3", 4'h3, O_LED);
    step("r1_gap0", 4'h4, O_NONE);
    step("r1_gap1", 4'h4, O_NONE);
    step("r1_ini_jog", 4'h6, O_ZE);
    step("r1_espera", 4'h7, O_NONE);
    bus.jogada = 1'b1;
    step("r1_registra", 4'h8, O_REG);
    bus.jogada = 1'b0;
    bus.igual = 1'b1;
    step("r1_compara", 4'h9, O_NONE);
    step("r1_prox_nivel", 4'hB, O_CL);

    // Round 2 (L=1): two shown values with a contaE cycle between them.
    bus.enderecoIgualSequencia = 1'b0;
    step("r2_ini_mostra", 4'h2, O_ZE);
    show_one("r2_v0");
    step("r2_prox_mostra", 4'h5, O_CE);
    bus.enderecoIgualSequencia = 1'b1;
    show_one("r2_v1");
    step("r2_ini_jog", 4'h6, O_ZE);
    step("r2_espera", 4'h7, O_NONE);
    bus.enderecoIgualSequencia = 1'b0;
    bus.jogada = 1'b1;
    step("r2_reg0", 4'h8, O_REG);
    bus.jogada = 1'b0;
    step("r2_cmp0", 4'h9, O_NONE);
    step("r2_prox_jog", 4'hA, O_CE);
    step("r2_espera1", 4'h7, O_NONE);
    bus.enderecoIgualSequencia = 1'b1;
    bus.fimL = 1'b1;
    bus.jogada = 1'b1;
    step("r2_reg1", 4'h8, O_REG);
    bus.jogada = 1'b0;
    step("r2_cmp1", 4'h9, O_NONE);
    step("ganhou", 4'hC, O_WIN);
    step("ganhou_hold", 4'hC, O_WIN);
    bus.iniciar = 1'b1;
    step("restart_win", 4'h1, O_PREP);
    bus.iniciar = 1'b0;
    bus.fimL = 1'b0;

    // Wrong first move, with iniciar held through the end state.
    step("l_ini_mostra", 4'h2, O_ZE);
    show_one("l_v0");
    step("l_ini_jog", 4'h6, O_ZE);
    step("l_espera", 4'h7, O_NONE);
    bus.jogada = 1'b1;
    step("l_reg", 4'h8, O_REG);
    bus.jogada = 1'b0;
    bus.igual = 1'b0;
    step("l_cmp", 4'h9, O_NONE);
    bus.iniciar = 1'b1;
    step("perdeu", 4'hD, O_LOSE);
    step("restart_lose", 4'h1, O_PREP);
    bus.iniciar = 1'b0;
    bus.igual = 1'b1;

    // Idle in ESPERA.
    step("t_ini_mostra", 4'h2, O_ZE);
    show_one("t_v0");
    step("t_ini_jog", 4'h6, O_ZE);
    step("t_espera", 4'h7, O_NONE);
`ifdef TIMEOUT_EN
    for (int i = 0; i < 9; i++) step("t_wait", 4'h7, O_NONE);
    step("timeout", 4'hE, O_TMO);
    bus.iniciar = 1'b1;
    step("restart_tmo", 4'h1, O_PREP);
    bus.iniciar = 1'b0;
    step("b_ini_mostra", 4'h2, O_ZE);
    show_one("b_v0");
    step("b_ini_jog", 4'h6, O_ZE);
    step("b_espera", 4'h7, O_NONE);
    for (int i = 0; i < 9; i++) step("b_wait", 4'h7, O_NONE);
`else
    for (int i = 0; i < 100; i++) step("t_wait", 4'h7, O_NONE);
`endif
    bus.jogada = 1'b1;
    step("boundary_reg", 4'h8, O_REG);
    bus.jogada = 1'b0;
    bus.fimL = 1'b0;
    step("b_cmp", 4'h9, O_NONE);
    step("b_prox_nivel", 4'hB, O_CL);
    step("b_ini_mostra2", 4'h2, O_ZE);
    step("b_led0", 4'h3, O_LED);
    step("b_led1", 4'h3, O_LED);

    // Reset in the middle of MOSTRA.
    reset = 1'b1;
    step("mid_reset", 4'h0, O_NONE);
    reset = 1'b0;
    step("after_reset", 4'h0, O_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
